// File: rtl/axi2mem_trans_unit_multi_if.sv
// Data-side handshake bundle of the axi2mem transfer buffer: read push/pop and write push/pop channels.
interface axi2mem_trans_unit_multi_if #(
    parameter int unsigned NB_LANES = 2,
    parameter int unsigned LANE_DW  = 32,
    parameter int unsigned ID_WIDTH = 6
);
    localparam int unsigned DW = NB_LANES * LANE_DW;
    localparam int unsigned SW = DW / 8;

    logic [DW-1:0]       rd_data_push_dat_i;
    logic [NB_LANES-1:0] rd_data_push_req_i;
    logic [NB_LANES-1:0] rd_data_push_gnt_o;
    logic [ID_WIDTH-1:0] rd_data_push_id_i;
    logic                rd_data_push_last_i;

    logic [DW-1:0]       rd_data_pop_dat_o;
    logic                rd_data_pop_req_i;
    logic                rd_data_pop_gnt_o;
    logic [ID_WIDTH-1:0] rd_data_pop_id_o;
    logic                rd_data_pop_last_o;

    logic [DW-1:0]       wr_data_push_dat_i;
    logic [SW-1:0]       wr_data_push_strb_i;
    logic                wr_data_push_req_i;
    logic                wr_data_push_gnt_o;

    logic [DW-1:0]       wr_data_pop_dat_o;
    logic [SW-1:0]       wr_data_pop_strb_o;
    logic [NB_LANES-1:0] wr_data_pop_req_i;
    logic [NB_LANES-1:0] wr_data_pop_gnt_o;

    modport slave (
        input  rd_data_push_dat_i, rd_data_push_req_i, rd_data_push_id_i, rd_data_push_last_i,
        output rd_data_push_gnt_o,
        input  rd_data_pop_req_i,
        output rd_data_pop_dat_o, rd_data_pop_gnt_o, rd_data_pop_id_o, rd_data_pop_last_o,
        input  wr_data_push_dat_i, wr_data_push_strb_i, wr_data_push_req_i,
        output wr_data_push_gnt_o,
        input  wr_data_pop_req_i,
        output wr_data_pop_dat_o, wr_data_pop_strb_o, wr_data_pop_gnt_o
    );

    modport master (
        output rd_data_push_dat_i, rd_data_push_req_i, rd_data_push_id_i, rd_data_push_last_i,
        input  rd_data_push_gnt_o,
        output rd_data_pop_req_i,
        input  rd_data_pop_dat_o, rd_data_pop_gnt_o, rd_data_pop_id_o, rd_data_pop_last_o,
        output wr_data_push_dat_i, wr_data_push_strb_i, wr_data_push_req_i,
        input  wr_data_push_gnt_o,
        output wr_data_pop_req_i,
        input  wr_data_pop_dat_o, wr_data_pop_strb_o, wr_data_pop_gnt_o
    );
endinterface

// File: rtl/axi2mem_trans_unit_multi.sv
// Transfer buffer between AXI and N TCDM lanes: per-lane read FIFOs packed into wide beats with an
// ID/last sideband FIFO, and wide write beats split into per-lane FIFOs.
module axi2mem_trans_unit_multi #(
    parameter int unsigned NB_LANES       = 2,
    parameter int unsigned LANE_DW        = 32,
    parameter int unsigned ID_WIDTH       = 6,
    parameter int unsigned LD_BUFFER_SIZE = 4,
    parameter int unsigned ST_BUFFER_SIZE = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    axi2mem_trans_unit_multi_if.slave bus,
    output logic rd_empty_o,
    output logic wr_empty_o
);
    localparam int unsigned LSW   = LANE_DW / 8;
    localparam int unsigned SB_W  = ID_WIDTH + 1;
    localparam int unsigned WE_W  = LSW + LANE_DW;
    localparam int unsigned LD_PW = $clog2(LD_BUFFER_SIZE);
    localparam int unsigned LD_CW = $clog2(LD_BUFFER_SIZE + 1);
    localparam int unsigned ST_PW = $clog2(ST_BUFFER_SIZE);
    localparam int unsigned ST_CW = $clog2(ST_BUFFER_SIZE + 1);

    // Pointer wrap supports non-power-of-two depths.
    function automatic logic [LD_PW-1:0] ld_inc(input logic [LD_PW-1:0] p);
        return (p == LD_PW'(LD_BUFFER_SIZE - 1)) ? '0 : LD_PW'(p + 1'b1);
    endfunction

    function automatic logic [ST_PW-1:0] st_inc(input logic [ST_PW-1:0] p);
        return (p == ST_PW'(ST_BUFFER_SIZE - 1)) ? '0 : ST_PW'(p + 1'b1);
    endfunction

    function automatic logic [LD_CW-1:0] ld_cnt(input logic [LD_CW-1:0] c, input logic push, input logic pop);
        if (push && !pop) return LD_CW'(c + 1'b1);
        if (pop && !push) return LD_CW'(c - 1'b1);
        return c;
    endfunction

    function automatic logic [ST_CW-1:0] st_cnt(input logic [ST_CW-1:0] c, input logic push, input logic pop);
        if (push && !pop) return ST_CW'(c + 1'b1);
        if (pop && !push) return ST_CW'(c - 1'b1);
        return c;
    endfunction

    logic [LD_CW-1:0]   rd_cnt  [NB_LANES];
    logic [LD_PW-1:0]   rd_wptr [NB_LANES];
    logic [LD_PW-1:0]   rd_rptr [NB_LANES];
    logic [LANE_DW-1:0] rd_mem  [NB_LANES][LD_BUFFER_SIZE];
    logic [NB_LANES-1:0] rd_ready, rd_valid, rd_push_gnt, rd_push;
    logic               rd_pop;

    logic [LD_CW-1:0]   sb_cnt;
    logic [LD_PW-1:0]   sb_wptr, sb_rptr;
    logic [SB_W-1:0]    sb_mem [LD_BUFFER_SIZE];
    logic               sb_ready, sb_valid, sb_push;

    logic [ST_CW-1:0]   wr_cnt  [NB_LANES];
    logic [ST_PW-1:0]   wr_wptr [NB_LANES];
    logic [ST_PW-1:0]   wr_rptr [NB_LANES];
    logic [WE_W-1:0]    wr_mem  [NB_LANES][ST_BUFFER_SIZE];
    logic [NB_LANES-1:0] wr_ready, wr_valid, wr_pop;
    logic               wr_push_gnt, wr_push;

    assign sb_ready = sb_cnt < LD_CW'(LD_BUFFER_SIZE);
    assign sb_valid = sb_cnt != '0;
    assign sb_push  = rd_push[0];

    // Handshake qualification; lane 0 also needs sideband room since it carries id/last.
    always_comb begin
        rd_ready    = '0;
        rd_valid    = '0;
        wr_ready    = '0;
        wr_valid    = '0;
        for (int k = 0; k < int'(NB_LANES); k++) begin
            rd_ready[k] = rd_cnt[k] < LD_CW'(LD_BUFFER_SIZE);
            rd_valid[k] = rd_cnt[k] != '0;
            wr_ready[k] = wr_cnt[k] < ST_CW'(ST_BUFFER_SIZE);
            wr_valid[k] = wr_cnt[k] != '0;
        end
        rd_push_gnt    = rd_ready;
        rd_push_gnt[0] = rd_ready[0] & sb_ready;
        rd_push        = bus.rd_data_push_req_i & rd_push_gnt;
        rd_pop         = bus.rd_data_pop_req_i & (&rd_valid) & sb_valid;
        wr_push_gnt    = &wr_ready;
        wr_push        = bus.wr_data_push_req_i & wr_push_gnt;
        wr_pop         = bus.wr_data_pop_req_i & wr_valid;
    end

    // Pointer/count state; clear discards any same-cycle push or pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(NB_LANES); k++) begin
                rd_cnt[k]  <= '0;
                rd_wptr[k] <= '0;
                rd_rptr[k] <= '0;
                wr_cnt[k]  <= '0;
                wr_wptr[k] <= '0;
                wr_rptr[k] <= '0;
            end
            sb_cnt  <= '0;
            sb_wptr <= '0;
            sb_rptr <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < int'(NB_LANES); k++) begin
                rd_cnt[k]  <= '0;
                rd_wptr[k] <= '0;
                rd_rptr[k] <= '0;
                wr_cnt[k]  <= '0;
                wr_wptr[k] <= '0;
                wr_rptr[k] <= '0;
            end
            sb_cnt  <= '0;
            sb_wptr <= '0;
            sb_rptr <= '0;
        end else begin
            for (int k = 0; k < int'(NB_LANES); k++) begin
                if (rd_push[k]) rd_wptr[k] <= ld_inc(rd_wptr[k]);
                if (rd_pop)     rd_rptr[k] <= ld_inc(rd_rptr[k]);
                rd_cnt[k] <= ld_cnt(rd_cnt[k], rd_push[k], rd_pop);
                if (wr_push)    wr_wptr[k] <= st_inc(wr_wptr[k]);
                if (wr_pop[k])  wr_rptr[k] <= st_inc(wr_rptr[k]);
                wr_cnt[k] <= st_cnt(wr_cnt[k], wr_push, wr_pop[k]);
            end
            if (sb_push) sb_wptr <= ld_inc(sb_wptr);
            if (rd_pop)  sb_rptr <= ld_inc(sb_rptr);
            sb_cnt <= ld_cnt(sb_cnt, sb_push, rd_pop);
        end
    end

    // Storage arrays are not reset; outputs are masked while a FIFO is empty.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(NB_LANES); k++) begin
            if (rd_push[k])
                rd_mem[k][rd_wptr[k]] <= bus.rd_data_push_dat_i[k*LANE_DW +: LANE_DW];
            if (wr_push)
                wr_mem[k][wr_wptr[k]] <= {bus.wr_data_push_strb_i[k*LSW +: LSW],
                                          bus.wr_data_push_dat_i[k*LANE_DW +: LANE_DW]};
        end
        if (sb_push) sb_mem[sb_wptr] <= {bus.rd_data_push_last_i, bus.rd_data_push_id_i};
    end

    always_comb begin
        bus.rd_data_pop_dat_o  = '0;
        bus.wr_data_pop_dat_o  = '0;
        bus.wr_data_pop_strb_o = '0;
        for (int k = 0; k < int'(NB_LANES); k++) begin
            if (rd_valid[k])
                bus.rd_data_pop_dat_o[k*LANE_DW +: LANE_DW] = rd_mem[k][rd_rptr[k]];
            if (wr_valid[k]) begin
                bus.wr_data_pop_dat_o[k*LANE_DW +: LANE_DW] = wr_mem[k][wr_rptr[k]][LANE_DW-1:0];
                bus.wr_data_pop_strb_o[k*LSW +: LSW]        = wr_mem[k][wr_rptr[k]][WE_W-1:LANE_DW];
            end
        end
        bus.rd_data_pop_id_o   = '0;
        bus.rd_data_pop_last_o = 1'b0;
        if (sb_valid) {bus.rd_data_pop_last_o, bus.rd_data_pop_id_o} = sb_mem[sb_rptr];
    end

    assign bus.rd_data_push_gnt_o = rd_push_gnt;
    assign bus.rd_data_pop_gnt_o  = (&rd_valid) & sb_valid;
    assign bus.wr_data_push_gnt_o = wr_push_gnt;
    assign bus.wr_data_pop_gnt_o  = wr_valid;
    assign rd_empty_o = ~(|rd_valid) & ~sb_valid;
    assign wr_empty_o = ~(|wr_valid);
endmodule

// File: tb/tb_axi2mem_trans_unit_multi.sv
// Bench for axi2mem_trans_unit_multi: queue-based reference model, vector table and directed sequences.
module tb_axi2mem_trans_unit_multi;
    localparam int unsigned NB  = 2;
    localparam int unsigned LDW = 32;
    localparam int unsigned IDW = 6;
    localparam int unsigned LD  = 3;
    localparam int unsigned ST  = 4;
    localparam int unsigned DW  = NB * LDW;
    localparam int unsigned LSW = LDW / 8;
    localparam int unsigned SW  = DW / 8;

    logic clk_i, rst_ni, clear_i, rd_empty_o, wr_empty_o;

    axi2mem_trans_unit_multi_if #(.NB_LANES(NB), .LANE_DW(LDW), .ID_WIDTH(IDW)) bus ();

    axi2mem_trans_unit_multi #(
        .NB_LANES(NB), .LANE_DW(LDW), .ID_WIDTH(IDW), .LD_BUFFER_SIZE(LD), .ST_BUFFER_SIZE(ST)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .bus(bus.slave),
        .rd_empty_o(rd_empty_o), .wr_empty_o(wr_empty_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks;
    int failures;

    // Reference model: plain queues per FIFO.
    logic [LDW-1:0]     rd_q [NB][$];
    logic [IDW:0]       sb_q [$];
    logic [LSW+LDW-1:0] wr_q [NB][$];

    logic [NB-1:0]  e_rd_push_gnt, e_wr_pop_gnt;
    logic           e_rd_pop_gnt, e_wr_push_gnt, e_rd_empty, e_wr_empty, e_last;
    logic [DW-1:0]  e_rd_dat, e_wr_dat;
    logic [SW-1:0]  e_wr_strb;
    logic [IDW-1:0] e_id;

    function automatic void model_clear();
        for (int k = 0; k < int'(NB); k++) begin
            rd_q[k].delete();
            wr_q[k].delete();
        end
        sb_q.delete();
    endfunction

    function automatic void model_eval();
        logic [LSW+LDW-1:0] w;
        e_rd_pop_gnt  = sb_q.size() > 0;
        e_wr_push_gnt = 1'b1;
        e_rd_empty    = sb_q.size() == 0;
        e_wr_empty    = 1'b1;
        e_rd_dat = '0; e_wr_dat = '0; e_wr_strb = '0;
        e_rd_push_gnt = '0; e_wr_pop_gnt = '0;
        for (int k = 0; k < int'(NB); k++) begin
            e_rd_push_gnt[k] = rd_q[k].size() < int'(LD);
            if (rd_q[k].size() == 0) e_rd_pop_gnt = 1'b0;
            else begin
                e_rd_dat[k*LDW +: LDW] = rd_q[k][0];
                e_rd_empty = 1'b0;
            end
            if (wr_q[k].size() >= int'(ST)) e_wr_push_gnt = 1'b0;
            if (wr_q[k].size() > 0) begin
                w = wr_q[k][0];
                e_wr_pop_gnt[k] = 1'b1;
                e_wr_dat[k*LDW +: LDW] = w[LDW-1:0];
                e_wr_strb[k*LSW +: LSW] = w[LSW+LDW-1:LDW];
                e_wr_empty = 1'b0;
            end
        end
        if (sb_q.size() >= int'(LD)) e_rd_push_gnt[0] = 1'b0;
        {e_last, e_id} = (sb_q.size() > 0) ? sb_q[0] : '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        model_eval();
        chk("rd_push_gnt", 64'(bus.rd_data_push_gnt_o), 64'(e_rd_push_gnt));
        chk("rd_pop_gnt",  64'(bus.rd_data_pop_gnt_o),  64'(e_rd_pop_gnt));
        chk("rd_pop_dat",  64'(bus.rd_data_pop_dat_o),  64'(e_rd_dat));
        chk("rd_pop_id",   64'(bus.rd_data_pop_id_o),   64'(e_id));
        chk("rd_pop_last", 64'(bus.rd_data_pop_last_o), 64'(e_last));
        chk("wr_push_gnt", 64'(bus.wr_data_push_gnt_o), 64'(e_wr_push_gnt));
        chk("wr_pop_gnt",  64'(bus.wr_data_pop_gnt_o),  64'(e_wr_pop_gnt));
        chk("wr_pop_dat",  64'(bus.wr_data_pop_dat_o),  64'(e_wr_dat));
        chk("wr_pop_strb", 64'(bus.wr_data_pop_strb_o), 64'(e_wr_strb));
        chk("rd_empty",    64'(rd_empty_o),             64'(e_rd_empty));
        chk("wr_empty",    64'(wr_empty_o),             64'(e_wr_empty));
    endtask

    // One clock: compare, then advance the model with the handshakes the model itself grants.
    task automatic step();
        logic [NB-1:0] rp, wp;
        logic rpop, wpush, clr, rlast;
        logic [DW-1:0] rdat, wdat;
        logic [SW-1:0] wstrb;
        logic [IDW-1:0] rid;
        compare_all();
        rp    = bus.rd_data_push_req_i & e_rd_push_gnt;
        rpop  = bus.rd_data_pop_req_i & e_rd_pop_gnt;
        wpush = bus.wr_data_push_req_i & e_wr_push_gnt;
        wp    = bus.wr_data_pop_req_i & e_wr_pop_gnt;
        clr   = clear_i;
        rdat  = bus.rd_data_push_dat_i;
        rid   = bus.rd_data_push_id_i;
        rlast = bus.rd_data_push_last_i;
        wdat  = bus.wr_data_push_dat_i;
        wstrb = bus.wr_data_push_strb_i;
        @(posedge clk_i);
        if (clr) model_clear();
        else begin
            if (rpop) begin
                for (int k = 0; k < int'(NB); k++) void'(rd_q[k].pop_front());
                void'(sb_q.pop_front());
            end
            for (int k = 0; k < int'(NB); k++) if (rp[k]) rd_q[k].push_back(rdat[k*LDW +: LDW]);
            if (rp[0]) sb_q.push_back({rlast, rid});
            for (int k = 0; k < int'(NB); k++) if (wp[k]) void'(wr_q[k].pop_front());
            if (wpush)
                for (int k = 0; k < int'(NB); k++)
                    wr_q[k].push_back({wstrb[k*LSW +: LSW], wdat[k*LDW +: LDW]});
        end
        #1;
    endtask

    task automatic idle();
        bus.rd_data_push_req_i  = '0;
        bus.rd_data_pop_req_i   = 1'b0;
        bus.wr_data_push_req_i  = 1'b0;
        bus.wr_data_pop_req_i   = '0;
        clear_i = 1'b0;
    endtask

    task automatic flush();
        idle();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    typedef struct {
        logic [63:0] dat;
        logic [7:0]  strb;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [3:0]  s1;
        logic [31:0] d1;
    } wvec_t;

    wvec_t wv [3];
    int pushed, popped;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        failures = 0;
        wv[0] = '{64'hAABBCCDD_11223344, 8'hF0, 4'h0, 32'h11223344, 4'hF, 32'hAABBCCDD};
        wv[1] = '{64'h01234567_89ABCDEF, 8'h0F, 4'hF, 32'h89ABCDEF, 4'h0, 32'h01234567};
        wv[2] = '{64'hDEADBEEF_CAFEF00D, 8'h5A, 4'hA, 32'hCAFEF00D, 4'h5, 32'hDEADBEEF};

        rst_ni = 1'b0;
        idle();
        bus.rd_data_push_dat_i  = '0;
        bus.rd_data_push_id_i   = '0;
        bus.rd_data_push_last_i = 1'b0;
        bus.wr_data_push_dat_i  = '0;
        bus.wr_data_push_strb_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_rd_push_gnt", 64'(bus.rd_data_push_gnt_o), 64'h3);
        chk("reset_wr_push_gnt", 64'(bus.wr_data_push_gnt_o), 64'h1);
        chk("reset_rd_pop_gnt",  64'(bus.rd_data_pop_gnt_o),  64'h0);
        chk("reset_wr_pop_gnt",  64'(bus.wr_data_pop_gnt_o),  64'h0);
        chk("reset_empty",       64'({rd_empty_o, wr_empty_o}), 64'h3);
        chk("reset_rd_dat",      64'(bus.rd_data_pop_dat_o),  64'h0);
        rst_ni = 1'b1;
        model_clear();

        // Lane 0 with sideband at cycle 1, lane 1 at cycle 3.
        bus.rd_data_push_dat_i = {32'h22222222, 32'h11111111};
        bus.rd_data_push_id_i  = 6'd5;
        bus.rd_data_push_req_i = 2'b01;
        step();
        idle();
        step();
        chk("partial_pop_gnt", 64'(bus.rd_data_pop_gnt_o), 64'h0);
        bus.rd_data_push_req_i = 2'b10;
        step();
        idle();
        chk("beat_pop_gnt", 64'(bus.rd_data_pop_gnt_o), 64'h1);
        chk("beat_dat",     64'(bus.rd_data_pop_dat_o), 64'h22222222_11111111);
        chk("beat_id",      64'(bus.rd_data_pop_id_o),  64'd5);
        chk("beat_last",    64'(bus.rd_data_pop_last_o), 64'h0);
        bus.rd_data_pop_req_i = 1'b1;
        step();
        idle();
        chk("beat_drained", 64'(rd_empty_o), 64'h1);

        // Fill lane 0 and sideband, then pop and push against a full lane 0 in the same cycle.
        for (int i = 0; i < int'(LD); i++) begin
            bus.rd_data_push_id_i   = IDW'(i + 10);
            bus.rd_data_push_last_i = (i == int'(LD) - 1);
            bus.rd_data_push_dat_i  = {32'h0, 32'(i + 100)};
            bus.rd_data_push_req_i  = 2'b01;
            step();
        end
        idle();
        chk("full_lane0_gnt", 64'(bus.rd_data_push_gnt_o), 64'h2);
        bus.rd_data_push_dat_i = {32'hBEEF0000, 32'h0};
        bus.rd_data_push_req_i = 2'b10;
        step();
        bus.rd_data_push_req_i = 2'b11;
        bus.rd_data_pop_req_i  = 1'b1;
        chk("full_pop_push_gnt0", 64'(bus.rd_data_push_gnt_o[0]), 64'h0);
        chk("full_pop_id", 64'(bus.rd_data_pop_id_o), 64'd10);
        step();
        idle();
        chk("after_pop_gnt0", 64'(bus.rd_data_push_gnt_o[0]), 64'h1);
        chk("after_pop_id",   64'(bus.rd_data_pop_id_o), 64'd11);
        flush();

        // Non-power-of-two depth wrap: ten beats in order with random backpressure.
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 200 && popped < 10; c++) begin
            bus.rd_data_push_req_i = (pushed < 10) ? 2'b11 : 2'b00;
            bus.rd_data_push_id_i  = IDW'(pushed);
            bus.rd_data_push_dat_i = {32'(pushed + 32'h1000), 32'(pushed)};
            bus.rd_data_pop_req_i  = 1'($urandom_range(0, 1));
            if (bus.rd_data_pop_req_i && bus.rd_data_pop_gnt_o) begin
                chk("wrap_id", 64'(bus.rd_data_pop_id_o), 64'(popped));
                popped++;
            end
            model_eval();
            if (pushed < 10 && (&e_rd_push_gnt)) pushed++;
            step();
        end
        idle();
        chk("wrap_count", 64'(popped), 64'd10);
        flush();

        // Write split vectors.
        foreach (wv[i]) begin
            bus.wr_data_push_dat_i  = wv[i].dat;
            bus.wr_data_push_strb_i = wv[i].strb;
            bus.wr_data_push_req_i  = 1'b1;
            step();
            idle();
            chk("wvec_gnt",   64'(bus.wr_data_pop_gnt_o), 64'h3);
            chk("wvec_s0",    64'(bus.wr_data_pop_strb_o[3:0]), 64'(wv[i].s0));
            chk("wvec_d0",    64'(bus.wr_data_pop_dat_o[31:0]), 64'(wv[i].d0));
            chk("wvec_s1",    64'(bus.wr_data_pop_strb_o[7:4]), 64'(wv[i].s1));
            chk("wvec_d1",    64'(bus.wr_data_pop_dat_o[63:32]), 64'(wv[i].d1));
            bus.wr_data_pop_req_i = 2'b11;
            step();
            idle();
        end

        // Lane 1 stalled: push stops after ST beats until lane 1 pops.
        for (int i = 0; i < int'(ST); i++) begin
            bus.wr_data_push_dat_i  = {32'(i + 50), 32'(i + 60)};
            bus.wr_data_push_strb_i = 8'(i + 1);
            bus.wr_data_push_req_i  = 1'b1;
            bus.wr_data_pop_req_i   = 2'b01;
            step();
        end
        chk("stall_wr_gnt", 64'(bus.wr_data_push_gnt_o), 64'h0);
        step();
        idle();
        bus.wr_data_pop_req_i = 2'b10;
        step();
        idle();
        chk("unstall_wr_gnt", 64'(bus.wr_data_push_gnt_o), 64'h1);
        flush();

        // Clear with pending beats and a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            bus.rd_data_push_dat_i = {32'(i + 7), 32'(i + 3)};
            bus.rd_data_push_id_i  = IDW'(i + 20);
            bus.rd_data_push_req_i = 2'b11;
            step();
        end
        clear_i = 1'b1;
        chk("clear_cycle_pop_gnt", 64'(bus.rd_data_pop_gnt_o), 64'h1);
        step();
        idle();
        chk("clear_pop_gnt",  64'(bus.rd_data_pop_gnt_o), 64'h0);
        chk("clear_rd_empty", 64'(rd_empty_o), 64'h1);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.rd_data_push_req_i  = NB'($urandom);
            bus.rd_data_push_dat_i  = {$urandom, $urandom};
            bus.rd_data_push_id_i   = IDW'($urandom);
            bus.rd_data_push_last_i = 1'($urandom);
            bus.rd_data_pop_req_i   = ($urandom_range(0, 3) != 0);
            bus.wr_data_push_req_i  = 1'($urandom);
            bus.wr_data_push_dat_i  = {$urandom, $urandom};
            bus.wr_data_push_strb_i = SW'($urandom);
            bus.wr_data_pop_req_i   = NB'($urandom);
            clear_i = ($urandom_range(0, 63) == 0);
            step();
        end

        // Asynchronous reset mid-transfer.
        idle();
        bus.rd_data_push_req_i = 2'b11;
        bus.wr_data_push_req_i = 1'b1;
        step();
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        model_clear();
        compare_all();
        #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 5; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
